dmem_ctrl: RTL and testbench

- Data-memory responder for the execute-stage load unit, sitting between that unit and the tagged memory bus.
- Accepts load requests (command/addr/size) from the execute stage and store requests from retire.
- Serialises requests onto the single memory port, tracks the outstanding bus tag, and returns the load word right-aligned to the requester with a one-cycle valid pulse.
- One transaction in flight at a time; load squash supported.

---
 rtl/dmem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory responder: serialises execute-stage loads and retire stores onto the
// single tagged memory port and returns right-aligned load data with a valid pulse.
`timescale 1ns/1ps
module dmem_ctrl #(
    parameter int XLEN       = 32,
    parameter int MEM_TAG_W  = 4,
    parameter int MEM_DATA_W = 64,
    parameter int MEM_SIZE   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            load2Dmem_command,
    input  logic [XLEN-1:0]       load2Dmem_addr,
    input  logic [MEM_SIZE-1:0]   load2Dmem_size,
    input  logic                  load_squash,
    input  logic [1:0]            store2Dmem_command,
    input  logic [XLEN-1:0]       store2Dmem_addr,
    input  logic [MEM_SIZE-1:0]   store2Dmem_size,
    input  logic [XLEN-1:0]       store2Dmem_data,
    output logic [1:0]            proc2mem_command,
    output logic [XLEN-1:0]       proc2mem_addr,
    output logic [MEM_SIZE-1:0]   proc2mem_size,
    output logic [MEM_DATA_W-1:0] proc2mem_data,
    input  logic [MEM_TAG_W-1:0]  mem2proc_response,
    input  logic [MEM_DATA_W-1:0] mem2proc_data,
    input  logic [MEM_TAG_W-1:0]  mem2proc_tag,
    output logic [XLEN-1:0]       Dmem2load_data,
    output logic                  Dmem2load_valid,
    output logic                  dmem_load_busy,
    output logic                  store_ack
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [MEM_SIZE-1:0] SZ_BYTE   = MEM_SIZE'(0);
    localparam logic [MEM_SIZE-1:0] SZ_DOUBLE = MEM_SIZE'(3);

    typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_WAIT, LD_DRAIN, ST_ISSUE} state_t;

    state_t                state_reg, state_next;
    logic [XLEN-1:0]       addr_reg, addr_next;
    logic [MEM_SIZE-1:0]   size_reg, size_next;
    logic [XLEN-1:0]       sdata_reg, sdata_next;
    logic [MEM_TAG_W-1:0]  tag_reg, tag_next;
    logic [XLEN-1:0]       load_data_reg, load_data_next;
    logic                  load_valid_reg, load_valid_next;
    logic                  store_ack_reg, store_ack_next;

    logic [XLEN-1:0]       half_word;
    logic [XLEN-1:0]       shifted;
    logic [XLEN-1:0]       size_mask;
    logic                  tag_hit;

    // Pick the 32-bit half, shift the addressed byte down, then keep only the access width.
    assign half_word = addr_reg[2] ? mem2proc_data[2*XLEN-1:XLEN] : mem2proc_data[XLEN-1:0];
    assign shifted   = half_word >> {addr_reg[1:0], 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < XLEN/8; gi++) begin : g_mask
            assign size_mask[gi*8 +: 8] =
                {8{(gi == 0) || (gi == 1 && size_reg != SZ_BYTE) || size_reg[1]}};
        end
    endgenerate

    assign tag_hit = (tag_reg != '0) && (mem2proc_tag == tag_reg);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            size_reg       <= '0;
            sdata_reg      <= '0;
            tag_reg        <= '0;
            load_data_reg  <= '0;
            load_valid_reg <= 1'b0;
            store_ack_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            size_reg       <= size_next;
            sdata_reg      <= sdata_next;
            tag_reg        <= tag_next;
            load_data_reg  <= load_data_next;
            load_valid_reg <= load_valid_next;
            store_ack_reg  <= store_ack_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        size_next        = size_reg;
        sdata_next       = sdata_reg;
        tag_next         = tag_reg;
        load_data_next   = load_data_reg;
        load_valid_next  = 1'b0;
        store_ack_next   = 1'b0;
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_size    = SZ_BYTE;
        proc2mem_data    = '0;
        case (state_reg)
            IDLE: begin
                // The pulse cycles block re-capture of a request the requester is still holding.
                if (store2Dmem_command == BUS_STORE && !store_ack_reg) begin
                    addr_next  = store2Dmem_addr;
                    size_next  = store2Dmem_size;
                    sdata_next = store2Dmem_data;
                    state_next = ST_ISSUE;
                end else if (load2Dmem_command == BUS_LOAD && !load_squash && !load_valid_reg) begin
                    addr_next  = load2Dmem_addr;
                    size_next  = load2Dmem_size;
                    state_next = LD_ISSUE;
                end
            end
            ST_ISSUE: begin
                proc2mem_command = BUS_STORE;
                proc2mem_addr    = addr_reg;
                proc2mem_size    = size_reg;
                proc2mem_data    = {{(MEM_DATA_W-XLEN){1'b0}}, sdata_reg};
                if (mem2proc_response != '0) begin
                    store_ack_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            LD_ISSUE: begin
                proc2mem_command = BUS_LOAD;
                proc2mem_addr    = {addr_reg[XLEN-1:3], 3'b000};
                proc2mem_size    = SZ_DOUBLE;
                if (mem2proc_response != '0) begin
                    tag_next   = mem2proc_response;
                    state_next = load_squash ? LD_DRAIN : LD_WAIT;
                end else if (load_squash) begin
                    state_next = IDLE;
                end
            end
            LD_WAIT: begin
                if (tag_hit) begin
                    tag_next   = '0;
                    state_next = IDLE;
                    if (!load_squash) begin
                        load_data_next  = shifted & size_mask;
                        load_valid_next = 1'b1;
                    end
                end else if (load_squash) begin
                    state_next = LD_DRAIN;
                end
            end
            LD_DRAIN: begin
                if (tag_hit) begin
                    tag_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dmem_load_busy  = (load2Dmem_command == BUS_LOAD && !load_valid_reg) ||
                             state_reg == LD_ISSUE || state_reg == LD_WAIT || state_reg == LD_DRAIN;
    assign Dmem2load_data  = load_data_reg;
    assign Dmem2load_valid = load_valid_reg;
    assign store_ack       = store_ack_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a tagged memory responder on the bus side, directed vectors for
// the documented cases, and random loads/stores checked against a byte-array model.
`timescale 1ns/1ps
module tb_dmem_ctrl;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        int          bp;
        int          lat;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        int          due;
    } ret_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  load2Dmem_command = BUS_NONE;
    logic [31:0] load2Dmem_addr = '0;
    logic [1:0]  load2Dmem_size = '0;
    logic        load_squash = 1'b0;
    logic [1:0]  store2Dmem_command = BUS_NONE;
    logic [31:0] store2Dmem_addr = '0;
    logic [1:0]  store2Dmem_size = '0;
    logic [31:0] store2Dmem_data = '0;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [1:0]  proc2mem_size;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [31:0] Dmem2load_data;
    logic        Dmem2load_valid;
    logic        dmem_load_busy;
    logic        store_ack;

    logic [7:0]  busmem [0:1023];
    logic [7:0]  refmem [0:1023];
    ret_t        retq[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [3:0]  rsp_tag = 4'd1;
    int          bp_cycles = 0;
    int          lat = 1;
    logic [31:0] last_data = '0;

    dmem_ctrl dut (
        .clock(clock), .reset(reset),
        .load2Dmem_command(load2Dmem_command), .load2Dmem_addr(load2Dmem_addr),
        .load2Dmem_size(load2Dmem_size), .load_squash(load_squash),
        .store2Dmem_command(store2Dmem_command), .store2Dmem_addr(store2Dmem_addr),
        .store2Dmem_size(store2Dmem_size), .store2Dmem_data(store2Dmem_data),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_size(proc2mem_size), .proc2mem_data(proc2mem_data),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag),
        .Dmem2load_data(Dmem2load_data), .Dmem2load_valid(Dmem2load_valid),
        .dmem_load_busy(dmem_load_busy), .store_ack(store_ack)
    );

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [63:0] rd_dword(input logic [31:0] a);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < 8; b++) v[8*b +: 8] = busmem[int'({a[9:3], 3'b000}) + b];
        return v;
    endfunction

    // Little-endian byte read of the reference memory.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < (1 << sz); b++) v[8*b +: 8] = refmem[(int'(a[9:0]) + b) % 1024];
        return v;
    endfunction

    // Memory side: back-pressure for bp_cycles, then accept with rsp_tag; loads return lat cycles later.
    initial begin
        ret_t r;
        int bp_count;
        logic [1:0] pcmd;
        logic [31:0] paddr;
        logic [63:0] pdata;
        logic [3:0] presp;
        logic [3:0] resp;
        bp_count = 0; pcmd = BUS_NONE; paddr = '0; pdata = '0; presp = '0;
        mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
        forever begin
            @(negedge clock);
            if (proc2mem_command != BUS_NONE && pcmd != BUS_NONE && presp == '0) begin
                check("bus_hold_cmd", 64'(proc2mem_command), 64'(pcmd));
                check("bus_hold_addr", 64'(proc2mem_addr), 64'(paddr));
                check("bus_hold_data", proc2mem_data, pdata);
            end
            resp = '0;
            if (proc2mem_command == BUS_NONE) bp_count = 0;
            else if (bp_count < bp_cycles) bp_count++;
            else begin
                resp = rsp_tag;
                bp_count = 0;
                if (proc2mem_command == BUS_LOAD) begin
                    r.tag = rsp_tag;
                    r.data = rd_dword(proc2mem_addr);
                    r.due = cyc + lat;
                    retq.push_back(r);
                end else begin
                    for (int b = 0; b < (1 << proc2mem_size); b++)
                        busmem[(int'(proc2mem_addr[9:0]) + b) % 1024] = proc2mem_data[8*b +: 8];
                end
            end
            pcmd = proc2mem_command; paddr = proc2mem_addr; pdata = proc2mem_data; presp = resp;
            mem2proc_response = resp;
            mem2proc_tag = '0;
            mem2proc_data = {$urandom, $urandom};
            if (retq.size() > 0 && retq[0].due <= cyc) begin
                r = retq.pop_front();
                mem2proc_tag = r.tag;
                mem2proc_data = r.data;
            end
        end
    end

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] exp, input string nm);
        int vcount = 0;
        bit busy_ok = 1, busy_at_valid = 0, seen = 0, done = 0;
        logic [31:0] got = '0, iaddr = '1;
        logic [1:0] isz = '0;
        load2Dmem_command = BUS_LOAD; load2Dmem_addr = a; load2Dmem_size = sz;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (!seen && proc2mem_command == BUS_LOAD) begin
                seen = 1; iaddr = proc2mem_addr; isz = proc2mem_size;
            end
            if (Dmem2load_valid) begin
                vcount++; got = Dmem2load_data; busy_at_valid = dmem_load_busy; done = 1;
                load2Dmem_command = BUS_NONE;
            end else if (!dmem_load_busy) busy_ok = 0;
        end
        load2Dmem_command = BUS_NONE;
        repeat (2) begin
            tick();
            if (Dmem2load_valid) vcount++;
        end
        check({nm, "_valid_cnt"}, 64'(vcount), 64'd1);
        check({nm, "_data"}, 64'(got), 64'(exp));
        check({nm, "_busy_drop"}, 64'(busy_at_valid), 64'd0);
        check({nm, "_busy_held"}, 64'(busy_ok), 64'd1);
        check({nm, "_issue_addr"}, 64'(iaddr), 64'({a[31:3], 3'b000}));
        check({nm, "_issue_size"}, 64'(isz), 64'(SZ_D));
        last_data = exp;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d, input string nm);
        int acks = 0;
        bit done = 0;
        store2Dmem_command = BUS_STORE; store2Dmem_addr = a; store2Dmem_size = sz; store2Dmem_data = d;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (store_ack) begin
                acks++; done = 1; store2Dmem_command = BUS_NONE;
            end
        end
        store2Dmem_command = BUS_NONE;
        tick();
        if (store_ack) acks++;
        check({nm, "_ack_cnt"}, 64'(acks), 64'd1);
        for (int b = 0; b < (1 << sz); b++) refmem[(int'(a[9:0]) + b) % 1024] = d[8*b +: 8];
    endtask

    // mode 0: squash while the issue is back-pressured; mode k>0: squash k-1 cycles after accept.
    task automatic squash_load(input logic [31:0] a, input logic [1:0] sz, input int mode, input string nm);
        int vcount = 0;
        bit seen = 0, go = 0;
        load2Dmem_command = BUS_LOAD; load2Dmem_addr = a; load2Dmem_size = sz;
        for (int i = 0; i < 50 && !go; i++) begin
            tick();
            if (Dmem2load_valid) vcount++;
            if (proc2mem_command == BUS_LOAD) seen = 1;
            else if (seen) go = 1;
            if (mode == 0 && seen) go = 1;
        end
        repeat ((mode > 0) ? mode - 1 : 0) begin
            tick();
            if (Dmem2load_valid) vcount++;
        end
        load_squash = 1'b1; load2Dmem_command = BUS_NONE;
        tick();
        if (Dmem2load_valid) vcount++;
        load_squash = 1'b0;
        for (int i = 0; i < 40 && (retq.size() != 0 || dmem_load_busy); i++) begin
            tick();
            if (Dmem2load_valid) vcount++;
        end
        tick();
        if (Dmem2load_valid) vcount++;
        check({nm, "_reached"}, 64'(go), 64'd1);
        check({nm, "_no_valid"}, 64'(vcount), 64'd0);
        check({nm, "_data_kept"}, 64'(Dmem2load_data), 64'(last_data));
        check({nm, "_busy_low"}, 64'(dmem_load_busy), 64'd0);
    endtask

    initial begin
        vec_t vt[6];
        logic [63:0] dw;
        logic [1:0] rsz;
        logic [31:0] raddr, rdata, got;
        int vcount, acks, ack_i, iss_i;
        bit seen, go, busy_ok;
        logic [1:0] first_cmd;

        for (int i = 0; i < 1024; i++) begin
            busmem[i] = 8'($urandom);
            refmem[i] = busmem[i];
        end
        dw = 64'h1122334455667788;
        for (int b = 0; b < 8; b++) begin
            busmem[256 + b] = dw[8*b +: 8];
            refmem[256 + b] = dw[8*b +: 8];
        end

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        check("rst_addr", 64'(proc2mem_addr), 64'd0);
        check("rst_data", proc2mem_data, 64'd0);
        check("rst_ld_data", 64'(Dmem2load_data), 64'd0);
        check("rst_valid", 64'(Dmem2load_valid), 64'd0);
        check("rst_ack", 64'(store_ack), 64'd0);
        check("rst_busy", 64'(dmem_load_busy), 64'd0);

        vt[0] = '{32'h104, SZ_W, 0, 5, 4'd3,  32'h11223344};
        vt[1] = '{32'h101, SZ_B, 0, 2, 4'd4,  32'h00000077};
        vt[2] = '{32'h106, SZ_H, 1, 3, 4'd5,  32'h00001122};
        vt[3] = '{32'h100, SZ_W, 4, 1, 4'd7,  32'h55667788};
        vt[4] = '{32'h107, SZ_B, 2, 4, 4'd15, 32'h00000011};
        vt[5] = '{32'h102, SZ_H, 0, 1, 4'd1,  32'h00005566};
        for (int i = 0; i < 6; i++) begin
            bp_cycles = vt[i].bp; lat = vt[i].lat; rsp_tag = vt[i].tag;
            do_load(vt[i].addr, vt[i].size, vt[i].exp, $sformatf("vec%0d", i));
        end
        bp_cycles = 0;

        // Store and load requested together: store goes first, load follows its ack.
        rsp_tag = 4'd6; lat = 2;
        store2Dmem_command = BUS_STORE; store2Dmem_addr = 32'h200; store2Dmem_size = SZ_W;
        store2Dmem_data = 32'hDEADBEEF;
        load2Dmem_command = BUS_LOAD; load2Dmem_addr = 32'h200; load2Dmem_size = SZ_W;
        first_cmd = BUS_NONE; acks = 0; ack_i = -1; iss_i = -1; vcount = 0; busy_ok = 1; got = '0;
        for (int i = 0; i < 100 && vcount == 0; i++) begin
            tick();
            if (first_cmd == BUS_NONE && proc2mem_command != BUS_NONE) first_cmd = proc2mem_command;
            if (proc2mem_command == BUS_LOAD && iss_i < 0) iss_i = i;
            if (store_ack) begin
                acks++; ack_i = i; store2Dmem_command = BUS_NONE;
            end
            if (Dmem2load_valid) begin
                vcount++; got = Dmem2load_data; load2Dmem_command = BUS_NONE;
            end else if (!dmem_load_busy) busy_ok = 0;
        end
        store2Dmem_command = BUS_NONE; load2Dmem_command = BUS_NONE;
        tick();
        if (store_ack) acks++;
        if (Dmem2load_valid) vcount++;
        for (int b = 0; b < 4; b++) refmem[512 + b] = store2Dmem_data[8*b +: 8];
        check("sim_first_cmd", 64'(first_cmd), 64'(BUS_STORE));
        check("sim_ack_cnt", 64'(acks), 64'd1);
        check("sim_load_after_ack", 64'(iss_i > ack_i && ack_i >= 0), 64'd1);
        check("sim_valid_cnt", 64'(vcount), 64'd1);
        check("sim_data", 64'(got), 64'hDEADBEEF);
        check("sim_busy_held", 64'(busy_ok), 64'd1);
        last_data = 32'hDEADBEEF;

        bp_cycles = 3; rsp_tag = 4'd8; lat = 2;
        squash_load(32'h100, SZ_W, 0, "sq_issue");
        bp_cycles = 0; rsp_tag = 4'd11; lat = 1;
        squash_load(32'h104, SZ_W, 1, "sq_same_cycle");
        rsp_tag = 4'd2; lat = 6;
        squash_load(32'h100, SZ_W, 2, "sq_wait");
        rsp_tag = 4'd3; lat = 3;
        do_load(32'h104, SZ_W, 32'h11223344, "after_squash");

        // Reset while waiting on tag 9; the stale return must be ignored afterwards.
        rsp_tag = 4'd9; lat = 8;
        load2Dmem_command = BUS_LOAD; load2Dmem_addr = 32'h100; load2Dmem_size = SZ_W;
        seen = 0; go = 0;
        for (int i = 0; i < 50 && !go; i++) begin
            tick();
            if (proc2mem_command == BUS_LOAD) seen = 1;
            else if (seen) go = 1;
        end
        tick();
        #1;
        reset = 1'b1; load2Dmem_command = BUS_NONE;
        #1;
        check("arst_reached", 64'(go), 64'd1);
        check("arst_ld_data", 64'(Dmem2load_data), 64'd0);
        check("arst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        check("arst_busy", 64'(dmem_load_busy), 64'd0);
        check("arst_valid", 64'(Dmem2load_valid), 64'd0);
        tick(); tick();
        reset = 1'b0;
        last_data = '0;
        vcount = 0;
        for (int i = 0; i < 40 && retq.size() != 0; i++) begin
            tick();
            if (Dmem2load_valid) vcount++;
        end
        tick();
        if (Dmem2load_valid) vcount++;
        check("stale_no_valid", 64'(vcount), 64'd0);
        check("stale_data", 64'(Dmem2load_data), 64'd0);
        rsp_tag = 4'd10; lat = 3;
        do_load(32'h101, SZ_B, 32'h00000077, "after_reset");

        for (int n = 0; n < 40; n++) begin
            rsz = 2'($urandom_range(0, 2));
            raddr = 32'h300 + 32'($urandom_range(0, 63));
            raddr = raddr & ~((32'd1 << rsz) - 32'd1);
            rdata = $urandom;
            bp_cycles = int'($urandom_range(0, 3));
            lat = int'($urandom_range(1, 6));
            rsp_tag = (rsp_tag == 4'd15) ? 4'd1 : rsp_tag + 4'd1;
            if ($urandom_range(0, 2) == 0) do_store(raddr, rsz, rdata, "rnd_st");
            else do_load(raddr, rsz, ref_load(raddr, rsz), "rnd_ld");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
